schedule_issue_queue: RTL and testbench

//  In-order issue queue with register scoreboard; the parametrised successor of the single-entry schedule stage.

---
 rtl/schedule_issue_queue_if.sv | 53 +++++
 rtl/schedule_issue_queue.sv | 110 +++++++++++
 tb/tb_schedule_issue_queue.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/schedule_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : schedule_issue_queue_if
// Brief    : Decode-to-execute issue queue bundle with writeback and status.
// Revision : 1.0 - initial release
// ============================================================================
interface schedule_issue_queue_if #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 96
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic                 FLUSH;
    logic                 STALL;
    logic                 MEM_WAIT;
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [PAYLOAD_W-1:0] IN_PAYLOAD;
    logic [4:0]           IN_RD;
    logic                 IN_RD_WE;
    logic [4:0]           IN_RS1;
    logic [4:0]           IN_RS2;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [PAYLOAD_W-1:0] OUT_PAYLOAD;
    logic [4:0]           OUT_RD;
    logic                 OUT_RD_WE;
    logic                 WB_VALID;
    logic [4:0]           WB_RD;
    logic [c_CNT_W-1:0]   COUNT;
    logic                 HAZARD;

    modport master (
        output FLUSH, STALL, MEM_WAIT,
        output IN_VALID, IN_PAYLOAD, IN_RD, IN_RD_WE, IN_RS1, IN_RS2,
        input  IN_READY,
        input  OUT_VALID, OUT_PAYLOAD, OUT_RD, OUT_RD_WE,
        output OUT_READY,
        output WB_VALID, WB_RD,
        input  COUNT, HAZARD
    );

    modport slave (
        input  FLUSH, STALL, MEM_WAIT,
        input  IN_VALID, IN_PAYLOAD, IN_RD, IN_RD_WE, IN_RS1, IN_RS2,
        output IN_READY,
        output OUT_VALID, OUT_PAYLOAD, OUT_RD, OUT_RD_WE,
        input  OUT_READY,
        input  WB_VALID, WB_RD,
        output COUNT, HAZARD
    );
endinterface
`default_nettype wire

// File: rtl/schedule_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : schedule_issue_queue
// Brief    : In-order issue queue with a 32-entry register busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module schedule_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 96
) (
    input  wire                    CLK,
    input  wire                    RST,
    schedule_issue_queue_if.slave  bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [4:0]           r_rd      [DEPTH];
    logic                 r_rd_we   [DEPTH];
    logic [4:0]           r_rs1     [DEPTH];
    logic [4:0]           r_rs2     [DEPTH];

    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;
    logic [31:0]          r_busy;
    logic [31:0]          w_busy_nxt;

    logic w_empty;
    logic w_full;
    logic w_in_ready;
    logic w_hazard;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(DEPTH));

    // Ready looks only at COUNT, so a full queue never accepts even while popping.
    assign w_in_ready = ~w_full & ~bus.MEM_WAIT & ~bus.FLUSH;

    assign w_hazard = r_busy[r_rs1[r_head]] | r_busy[r_rs2[r_head]]
                    | (r_rd_we[r_head] & r_busy[r_rd[r_head]]);

    assign w_out_valid = ~w_empty & ~w_hazard & ~bus.STALL & ~bus.MEM_WAIT & ~bus.FLUSH;

    assign w_push = bus.IN_VALID & w_in_ready;
    assign w_pop  = w_out_valid & bus.OUT_READY;

    assign bus.IN_READY    = w_in_ready;
    assign bus.OUT_VALID   = w_out_valid;
    assign bus.HAZARD      = ~w_empty & w_hazard;
    assign bus.COUNT       = r_count;
    assign bus.OUT_PAYLOAD = w_empty ? '0   : r_payload[r_head];
    assign bus.OUT_RD      = w_empty ? 5'd0 : r_rd[r_head];
    assign bus.OUT_RD_WE   = w_empty ? 1'b0 : r_rd_we[r_head];

    // Entry storage needs no reset: empty slots are masked by COUNT.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_payload[r_tail] <= bus.IN_PAYLOAD;
            r_rd[r_tail]      <= bus.IN_RD;
            r_rd_we[r_tail]   <= bus.IN_RD_WE;
            r_rs1[r_tail]     <= bus.IN_RS1;
            r_rs2[r_tail]     <= bus.IN_RS2;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || bus.FLUSH) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Set is applied after clear so an issuing writer wins over a completing one.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.WB_VALID) begin
            w_busy_nxt[bus.WB_RD] = 1'b0;
        end
        if (w_pop && r_rd_we[r_head] && (r_rd[r_head] != 5'd0)) begin
            w_busy_nxt[r_rd[r_head]] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || bus.FLUSH) begin
            r_busy <= '0;
        end else if (!bus.MEM_WAIT) begin
            r_busy <= w_busy_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_schedule_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_schedule_issue_queue
// Brief    : Scoreboard bench for schedule_issue_queue (DEPTH=4, PAYLOAD_W=96).
// Revision : 1.0 - initial release
// ============================================================================
module tb_schedule_issue_queue;
    localparam int c_DEPTH = 4;
    localparam int c_PW    = 96;

    typedef struct {
        logic [c_PW-1:0] pl;
        logic [4:0]      rd;
        logic            we;
    } exp_t;

    logic CLK;
    logic RST;
    int   r_vec    = 0;
    int   r_err    = 0;
    int   r_issued = 0;
    exp_t r_exp_q[$];
    exp_t r_mon_e;

    schedule_issue_queue_if #(.DEPTH(c_DEPTH), .PAYLOAD_W(c_PW)) v ();

    schedule_issue_queue #(.DEPTH(c_DEPTH), .PAYLOAD_W(c_PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (v)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        r_vec++;
        if (obs !== want) begin
            r_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    function automatic logic [c_PW-1:0] mkpl(input int id);
        logic [31:0] w;
        w = 32'(id);
        return {32'hC0DE_0000 | w, ~w, w * 32'h9E37_79B9};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        v.IN_VALID   = 1'b0;
        v.IN_PAYLOAD = '0;
        v.IN_RD      = 5'd0;
        v.IN_RD_WE   = 1'b0;
        v.IN_RS1     = 5'd0;
        v.IN_RS2     = 5'd0;
    endtask

    task automatic set_in(input int id, input logic [4:0] rd, input logic we,
                          input logic [4:0] rs1, input logic [4:0] rs2);
        v.IN_VALID   = 1'b1;
        v.IN_PAYLOAD = mkpl(id);
        v.IN_RD      = rd;
        v.IN_RD_WE   = we;
        v.IN_RS1     = rs1;
        v.IN_RS2     = rs2;
    endtask

    task automatic wb(input logic [4:0] rd);
        v.WB_VALID = 1'b1;
        v.WB_RD    = rd;
        step();
        v.WB_VALID = 1'b0;
        v.WB_RD    = 5'd0;
    endtask

    // Mid-cycle monitor: occupancy model, issue comparison, then enqueue tracking.
    always @(negedge CLK) begin
        if (RST) begin
            r_exp_q.delete();
        end else begin
            chk("count_model", 128'(v.COUNT), 128'(r_exp_q.size()));
            if (v.FLUSH) begin
                r_exp_q.delete();
            end else begin
                if (v.OUT_VALID && v.OUT_READY) begin
                    if (r_exp_q.size() == 0) begin
                        chk("sb_underflow", 128'd1, 128'd0);
                    end else begin
                        r_mon_e = r_exp_q.pop_front();
                        chk("issue_payload", 128'(v.OUT_PAYLOAD), 128'(r_mon_e.pl));
                        chk("issue_rd",      128'(v.OUT_RD),      128'(r_mon_e.rd));
                        chk("issue_rd_we",   128'(v.OUT_RD_WE),   128'(r_mon_e.we));
                        r_issued++;
                    end
                end
                if (v.IN_VALID && v.IN_READY) begin
                    r_exp_q.push_back('{pl: v.IN_PAYLOAD, rd: v.IN_RD, we: v.IN_RD_WE});
                end
            end
        end
    end

    initial begin
        RST         = 1'b1;
        v.FLUSH     = 1'b0;
        v.STALL     = 1'b0;
        v.MEM_WAIT  = 1'b0;
        v.OUT_READY = 1'b0;
        v.WB_VALID  = 1'b0;
        v.WB_RD     = 5'd0;
        idle_in();
        step();
        step();
        RST = 1'b0;
        #1;
        chk("rst_count",   128'(v.COUNT),       128'd0);
        chk("rst_in_rdy",  128'(v.IN_READY),    128'd1);
        chk("rst_out_vld", 128'(v.OUT_VALID),   128'd0);
        chk("rst_hazard",  128'(v.HAZARD),      128'd0);
        chk("rst_out_pl",  128'(v.OUT_PAYLOAD), 128'd0);
        chk("rst_out_rd",  128'(v.OUT_RD),      128'd0);

        // Four independent instructions issue back to back, one cycle after push.
        v.OUT_READY = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_in(i, 5'(i), 1'b1, 5'd0, 5'd0);
            #1;
            if (i > 1) begin
                chk("t1_out_vld", 128'(v.OUT_VALID), 128'd1);
                chk("t1_out_rd",  128'(v.OUT_RD),    128'(i - 1));
            end
            step();
        end
        idle_in();
        chk("t1_last_rd", 128'(v.OUT_RD), 128'd4);
        step();
        chk("t1_count", 128'(v.COUNT), 128'd0);
        chk("t1_issued", 128'(r_issued), 128'd4);
        for (int i = 1; i <= 4; i++) wb(5'(i));

        // Fill to DEPTH; a pop with a push pending must not let the push in.
        v.OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(10 + i, 5'd0, 1'b0, 5'd0, 5'd0);
            #1;
            chk("t2_in_rdy", 128'(v.IN_READY), (i < 4) ? 128'd1 : 128'd0);
            step();
        end
        chk("t2_count_full", 128'(v.COUNT), 128'd4);
        set_in(20, 5'd0, 1'b0, 5'd0, 5'd0);
        v.OUT_READY = 1'b1;
        #1;
        chk("t2_in_rdy_pop", 128'(v.IN_READY),  128'd0);
        chk("t2_out_vld",    128'(v.OUT_VALID), 128'd1);
        step();
        idle_in();
        v.OUT_READY = 1'b0;
        chk("t2_count_3", 128'(v.COUNT), 128'd3);
        v.OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t2_drain", 128'(v.COUNT), 128'd0);
        chk("t2_issued", 128'(r_issued), 128'd8);

        // RAW: consumer of x5 waits for writeback, no same-cycle bypass.
        set_in(30, 5'd5, 1'b1, 5'd0, 5'd0);
        step();
        set_in(31, 5'd6, 1'b0, 5'd5, 5'd0);
        #1;
        chk("t3_prod_vld", 128'(v.OUT_VALID), 128'd1);
        step();
        idle_in();
        chk("t3_hazard",  128'(v.HAZARD),    128'd1);
        chk("t3_blocked", 128'(v.OUT_VALID), 128'd0);
        step();
        chk("t3_still_blk", 128'(v.OUT_VALID), 128'd0);
        v.WB_VALID = 1'b1;
        v.WB_RD    = 5'd5;
        #1;
        chk("t3_no_bypass", 128'(v.OUT_VALID), 128'd0);
        step();
        v.WB_VALID = 1'b0;
        chk("t3_released", 128'(v.OUT_VALID), 128'd1);
        chk("t3_hz_clear", 128'(v.HAZARD),    128'd0);
        step();
        chk("t3_count", 128'(v.COUNT), 128'd0);

        // WAW on x7, then two rd=x0 writers that must not block each other.
        set_in(40, 5'd7, 1'b1, 5'd0, 5'd0);
        step();
        set_in(41, 5'd7, 1'b1, 5'd0, 5'd0);
        #1;
        chk("t4_first_vld", 128'(v.OUT_VALID), 128'd1);
        step();
        set_in(42, 5'd0, 1'b1, 5'd0, 5'd0);
        #1;
        chk("t4_waw_hz",  128'(v.HAZARD),    128'd1);
        chk("t4_waw_blk", 128'(v.OUT_VALID), 128'd0);
        chk("t4_head_rd", 128'(v.OUT_RD),    128'd7);
        step();
        set_in(43, 5'd0, 1'b1, 5'd0, 5'd0);
        step();
        idle_in();
        chk("t4_count3",  128'(v.COUNT),  128'd3);
        chk("t4_hz_hold", 128'(v.HAZARD), 128'd1);
        wb(5'd7);
        chk("t4_waw_rel", 128'(v.OUT_VALID), 128'd1);
        step();
        chk("t4_x0_a", 128'(v.OUT_VALID), 128'd1);
        step();
        chk("t4_x0_b", 128'(v.OUT_VALID), 128'd1);
        step();
        chk("t4_count0", 128'(v.COUNT), 128'd0);
        chk("t4_issued", 128'(r_issued), 128'd14);
        wb(5'd7);

        // Flush with three entries and x3 busy; incoming push is dropped.
        set_in(50, 5'd3, 1'b1, 5'd0, 5'd0);
        step();
        idle_in();
        step();
        v.OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(51 + i, 5'(9 + i), 1'b0, 5'd3, 5'd0);
            step();
        end
        idle_in();
        chk("t5_count3", 128'(v.COUNT),  128'd3);
        chk("t5_hz",     128'(v.HAZARD), 128'd1);
        v.FLUSH = 1'b1;
        set_in(60, 5'd1, 1'b1, 5'd0, 5'd0);
        #1;
        chk("t5_fl_in_rdy", 128'(v.IN_READY),  128'd0);
        chk("t5_fl_out_vld", 128'(v.OUT_VALID), 128'd0);
        step();
        v.FLUSH = 1'b0;
        idle_in();
        chk("t5_count0",   128'(v.COUNT),       128'd0);
        chk("t5_out_vld",  128'(v.OUT_VALID),   128'd0);
        chk("t5_hz0",      128'(v.HAZARD),      128'd0);
        chk("t5_bubble",   128'(v.OUT_PAYLOAD), 128'd0);
        set_in(61, 5'd3, 1'b1, 5'd3, 5'd3);
        v.OUT_READY = 1'b1;
        step();
        idle_in();
        chk("t5_busy_clr", 128'(v.HAZARD),    128'd0);
        chk("t5_issue",    128'(v.OUT_VALID), 128'd1);
        step();
        chk("t5_drain", 128'(v.COUNT), 128'd0);
        wb(5'd3);

        // MEM_WAIT freezes everything; STALL alone still accepts.
        v.OUT_READY = 1'b0;
        set_in(70, 5'd0, 1'b0, 5'd0, 5'd0);
        step();
        set_in(71, 5'd0, 1'b0, 5'd0, 5'd0);
        step();
        chk("t6_count2", 128'(v.COUNT), 128'd2);
        v.MEM_WAIT  = 1'b1;
        v.OUT_READY = 1'b1;
        set_in(72, 5'd0, 1'b0, 5'd0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t6_mw_count",  128'(v.COUNT),       128'd2);
            chk("t6_mw_in_rdy", 128'(v.IN_READY),    128'd0);
            chk("t6_mw_vld",    128'(v.OUT_VALID),   128'd0);
            chk("t6_mw_pl",     128'(v.OUT_PAYLOAD), 128'(mkpl(70)));
            step();
        end
        v.MEM_WAIT = 1'b0;
        v.STALL    = 1'b1;
        set_in(73, 5'd0, 1'b0, 5'd0, 5'd0);
        #1;
        chk("t6_st_in_rdy", 128'(v.IN_READY),  128'd1);
        chk("t6_st_vld",    128'(v.OUT_VALID), 128'd0);
        step();
        idle_in();
        chk("t6_st_count", 128'(v.COUNT),     128'd3);
        chk("t6_st_vld2",  128'(v.OUT_VALID), 128'd0);
        v.STALL = 1'b0;
        #1;
        chk("t6_resume", 128'(v.OUT_VALID), 128'd1);
        for (int i = 0; i < 3; i++) step();
        chk("t6_count0", 128'(v.COUNT), 128'd0);
        chk("t6_issued", 128'(r_issued), 128'd19);
        chk("sb_empty",  128'(r_exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", r_vec, r_err);
        $finish;
    end
endmodule
`default_nettype wire
